alu_op_scheduler: RTL

Shares the registered four-function ALU (mul/add/div/sub, one-hot select, 1-cycle registered output) between two requesters. Round-robin arbitration, one operation in flight at a time. The block drives the ALU select lines and operands only during the issue cycle, and holds them at zero otherwise (operand isolation for low power). It traps divide-by-zero without touching the ALU and returns each result with the requester ID over a valid/ready response port.

---
 rtl/alu_op_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: shares one registered four-function ALU between two
// requesters with round-robin arbitration, one operation in flight at a time.
// ALU selects and operands are driven only in ISSUE and held at zero
// otherwise. Divide-by-zero is trapped without touching the ALU.
//
// state | meaning
// IDLE  | arbitrate; accept one request
// ISSUE | drive ALU operands and the one-hot select for one cycle
// WAIT  | ALU result registered; capture it into the response register
// RESP  | hold response until rsp_ready
module alu_op_scheduler #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [1:0]     req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [1:0]     req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_sel1,
  output logic           alu_sel2,
  output logic           alu_sel3,
  output logic           alu_sel4,
  input  logic [2*W-1:0] alu_out,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_data,
  output logic           rsp_err,
  input  logic           rsp_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic           id_q, id_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           err_q, err_d;
  logic [2*W-1:0] data_q, data_d;

  logic           grant0, grant1;
  logic [3:0]     sel;

  // Round-robin grant: on a tie the requester not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_q;
      grant1 = ~last_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;

  assign alu_sel1 = sel[0];
  assign alu_sel2 = sel[1];
  assign alu_sel3 = sel[2];
  assign alu_sel4 = sel[3];

  assign rsp_id   = id_q;
  assign rsp_data = data_q;
  assign rsp_err  = err_q;

  // Next-state, operand latching and ALU/response drive.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    err_d     = err_q;
    data_d    = data_q;
    alu_a     = '0;
    alu_b     = '0;
    sel       = 4'b0000;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          id_d    = grant1;
          last_d  = grant1;
          op_d    = grant1 ? req1_op : req0_op;
          a_d     = grant1 ? req1_a : req0_a;
          b_d     = grant1 ? req1_b : req0_b;
          // Trap decided at accept so ISSUE can keep the ALU fully quiet.
          err_d   = (op_d == 2'b10) && (b_d == '0);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!err_q) begin
          alu_a = a_q;
          alu_b = b_q;
          sel   = 4'b0001 << op_q;
        end
        state_d = WAIT;
      end
      WAIT: begin
        data_d  = err_q ? '0 : alu_out;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

endmodule
